// File: rtl/fifo_rd_arb_if.sv
// Handshake bundle between the FIFO read arbiter and its FIFO bank / downstream sink.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface fifo_rd_arb_if #(
  parameter int NUM_PORTS = 4,
  parameter int W_WIDTH   = 32
);
  logic                           arb_en;
  logic [NUM_PORTS-1:0]           fifo_empty;
  logic [NUM_PORTS-1:0]           fifo_last;
  logic [NUM_PORTS*W_WIDTH-1:0]   fifo_data;
  logic                           out_ready;
  logic [NUM_PORTS-1:0]           fifo_rd_en;
  logic [NUM_PORTS-1:0]           grant;
  logic [W_WIDTH-1:0]             data_out;
  logic                           data_valid;
  logic                           busy;

  modport master (
    output arb_en, fifo_empty, fifo_last, fifo_data, out_ready,
    input  fifo_rd_en, grant, data_out, data_valid, busy
  );

  modport slave (
    input  arb_en, fifo_empty, fifo_last, fifo_data, out_ready,
    output fifo_rd_en, grant, data_out, data_valid, busy
  );
endinterface

// File: rtl/fifo_rd_arb.sv
// Round-robin burst read arbiter over NUM_PORTS show-ahead FIFOs (IDLE/XFER/FLUSH).
// Define FIFO_ARB_BURST_LIMIT_EN to release a grant after MAX_BURST reads.
module fifo_rd_arb #(
  parameter int NUM_PORTS = 4,
  parameter int W_WIDTH   = 32,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  fifo_rd_arb_if.slave  bus
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("MAX_BURST must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_e;

  state_e               state_q;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        gidx_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic [W_WIDTH-1:0]   data_q;
  logic                 valid_q;

  logic                 found_d;
  logic [PW-1:0]        sel_d;
  logic [PW-1:0]        cand_d;
  int                   idx_d;
  logic                 rd_d;
  logic                 last_d;
  logic                 limit_d;
  logic [W_WIDTH-1:0]   word_d;
  logic [NUM_PORTS-1:0] rd_vec_d;

  // First non-empty port strictly after the last-granted one, wrapping around.
  always_comb begin
    found_d = 1'b0;
    sel_d   = '0;
    cand_d  = '0;
    idx_d   = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx_d  = (int'(ptr_q) + k) % NUM_PORTS;
      cand_d = PW'(idx_d);
      if (!found_d && !bus.fifo_empty[cand_d]) begin
        found_d = 1'b1;
        sel_d   = cand_d;
      end
    end
  end

  always_comb begin
    word_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gidx_q == PW'(i)) word_d = bus.fifo_data[i*W_WIDTH +: W_WIDTH];
    end
  end

  assign rd_d   = (state_q == XFER) && bus.out_ready && bus.arb_en &&
                  !bus.fifo_empty[gidx_q] && !rst;
  assign last_d = bus.fifo_last[gidx_q];

  always_comb begin
    rd_vec_d         = '0;
    rd_vec_d[gidx_q] = rd_d;
  end

`ifdef FIFO_ARB_BURST_LIMIT_EN
  logic [7:0] burst_q;

  // Cleared while idle so every new grant starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) burst_q <= '0;
    else if (rd_d)              burst_q <= burst_q + 8'd1;
  end

  assign limit_d = (burst_q == 8'(MAX_BURST - 1));
`else
  assign limit_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NUM_PORTS - 1);
      gidx_q  <= '0;
      grant_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_d;
      if (rd_d) data_q <= word_d;
      case (state_q)
        IDLE: begin
          if (bus.arb_en && found_d) begin
            state_q <= XFER;
            gidx_q  <= sel_d;
            ptr_q   <= sel_d;
            grant_q <= NUM_PORTS'(1) << sel_d;
          end
        end
        XFER: begin
          if (rd_d) begin
            if (last_d || limit_d) begin
              state_q <= FLUSH;
              grant_q <= '0;
            end
          end else if (bus.fifo_empty[gidx_q] || !bus.arb_en) begin
            state_q <= FLUSH;
            grant_q <= '0;
          end
        end
        FLUSH:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are masked while rst is high so a word read just before reset never surfaces.
  assign bus.fifo_rd_en = rd_vec_d;
  assign bus.grant      = rst ? '0 : grant_q;
  assign bus.data_out   = rst ? '0 : data_q;
  assign bus.data_valid = valid_q && !rst;
  assign bus.busy       = (state_q != IDLE) && !rst;
endmodule

// File: tb/tb_fifo_rd_arb.sv
// Scoreboard bench for fifo_rd_arb: queue-modelled show-ahead FIFOs feed the arbiter,
// expected words, grants and burst lengths are queued at stimulus time and checked on output.
module tb_fifo_rd_arb;
  localparam int NP = 4;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_arb_if #(.NUM_PORTS(NP), .W_WIDTH(W)) bus ();

  fifo_rd_arb #(.NUM_PORTS(NP), .W_WIDTH(W), .MAX_BURST(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [W-1:0] fq [NP][$];
  bit           fl [NP][$];
  logic [W-1:0] sb [$];
  int           exp_gnt [$];
  int           exp_len [$];
  logic [NP-1:0] rd_s = '0;
  logic [NP-1:0] prev_gnt = '0;
  int           burst_cnt = 0;

  function automatic logic [W-1:0] word(input int p, input int k);
    return {8'(p), 24'(k)};
  endfunction

  task automatic refresh();
    for (int i = 0; i < NP; i++) begin
      bus.fifo_empty[i]       = (fq[i].size() == 0);
      bus.fifo_last[i]        = (fq[i].size() != 0) ? fl[i][0] : 1'b0;
      bus.fifo_data[i*W +: W] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic load(input int p, input int k0, input int n, input int last_every);
    for (int k = 0; k < n; k++) begin
      fq[p].push_back(word(p, k0 + k));
      fl[p].push_back(last_every != 0 && ((k + 1) % last_every) == 0);
    end
    refresh();
  endtask

  task automatic expect_words(input int p, input int k0, input int n);
    for (int k = 0; k < n; k++) sb.push_back(word(p, k0 + k));
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NP; i++) begin
      fq[i].delete();
      fl[i].delete();
    end
    refresh();
  endtask

  // FIFO model: pop whatever the arbiter strobed during the cycle that just ended.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NP; i++) begin
      if (rd_s[i] && fq[i].size() != 0) begin
        void'(fq[i].pop_front());
        void'(fl[i].pop_front());
      end
    end
    refresh();
  end

  // Output monitor: data against scoreboard, grant/burst length against expectation queues.
  always @(negedge clk) begin
    int e;
    rd_s = bus.fifo_rd_en;
    if (bus.data_valid) begin
      if (sb.size() == 0) chk("dv_unexpected", bus.data_valid, 0);
      else                chk("data", bus.data_out, sb.pop_front());
    end
    if (bus.grant != prev_gnt) begin
      if (prev_gnt != '0) begin
        e = (exp_len.size() != 0) ? exp_len.pop_front() : -1;
        chk("burst_len", burst_cnt, e);
      end
      if (bus.grant != '0) begin
        e = (exp_gnt.size() != 0) ? (1 << exp_gnt.pop_front()) : 0;
        chk("grant", bus.grant, e);
        burst_cnt = 0;
      end
    end
    if (bus.fifo_rd_en != '0) begin
      burst_cnt++;
      chk("rd_in_grant", bus.fifo_rd_en & ~bus.grant, 0);
    end
    prev_gnt = bus.grant;
  end

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_rd_en"},  bus.fifo_rd_en, 0);
    chk({pfx, "_grant"},  bus.grant, 0);
    chk({pfx, "_dout"},   bus.data_out, 0);
    chk({pfx, "_dvalid"}, bus.data_valid, 0);
    chk({pfx, "_busy"},   bus.busy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_fifos();
    @(negedge clk);
    chk_quiet("rst");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok = 1'b0;
    int left;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      left = 0;
      for (int i = 0; i < NP; i++) left += fq[i].size();
      if (!bus.busy && bus.grant == '0 && sb.size() == 0 && left == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, "_timeout"}, ok, 1);
    chk({tag, "_sb_left"},  sb.size(), 0);
    chk({tag, "_gnt_left"}, exp_gnt.size(), 0);
    chk({tag, "_len_left"}, exp_len.size(), 0);
  endtask

  task automatic wait_reads(input string tag, input int n, input int budget);
    int seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clk);
      if (bus.fifo_rd_en != '0) seen++;
    end
    if (seen < n) chk({tag, "_reads_timeout"}, seen, n);
  endtask

  initial begin
    bus.arb_en    = 1'b1;
    bus.out_ready = 1'b1;
    clear_fifos();
    repeat (2) @(posedge clk);

    // Two packets on ports 0 and 2, served in port order.
    do_reset();
    load(0, 0, 3, 3);
    load(2, 0, 3, 3);
    expect_words(0, 0, 3);
    expect_words(2, 0, 3);
    exp_gnt = '{0, 2};
    exp_len = '{3, 3};
    wait_done("two_ports", 200);

    // All ports busy, packets of two words: full round-robin rotation.
    do_reset();
    load(0, 0, 4, 2);
    for (int p = 1; p < NP; p++) load(p, 0, 2, 2);
    expect_words(0, 0, 2);
    for (int p = 1; p < NP; p++) expect_words(p, 0, 2);
    expect_words(0, 2, 2);
    exp_gnt = '{0, 1, 2, 3, 0};
    exp_len = '{2, 2, 2, 2, 2};
    wait_done("round_robin", 300);

    // Long packet without end marker on port 1.
    do_reset();
    load(1, 0, 40, 0);
    expect_words(1, 0, 40);
`ifdef FIFO_ARB_BURST_LIMIT_EN
    exp_gnt = '{1, 1, 1};
    exp_len = '{16, 16, 8};
`else
    exp_gnt = '{1};
    exp_len = '{40};
`endif
    wait_done("long_burst", 400);

    // Downstream stall for five cycles in the middle of a burst.
    do_reset();
    load(2, 0, 8, 8);
    expect_words(2, 0, 8);
    exp_gnt = '{2};
    exp_len = '{8};
    wait_reads("stall", 3, 50);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_rd_en", bus.fifo_rd_en, 0);
      chk("stall_grant", bus.grant, 4'b0100);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done("stall", 200);

    // Reset after two reads: second word must never be delivered, pointer restarts.
    do_reset();
    load(1, 0, 10, 0);
    expect_words(1, 0, 1);
    exp_gnt = '{1};
    exp_len = '{2};
    wait_reads("midrst", 2, 50);
    @(posedge clk); #1;
    rst = 1'b1;
    clear_fifos();
    @(negedge clk);
    chk_quiet("midrst_during");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("midrst_after");
    chk("midrst_sb_left", sb.size(), 0);
    load(1, 100, 1, 1);
    load(3, 100, 1, 1);
    expect_words(1, 100, 1);
    expect_words(3, 100, 1);
    exp_gnt = '{1, 3};
    exp_len = '{1, 1};
    wait_done("post_rst", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
